obi_magic_mem_bridge: RTL and testbench
=======================================

Name: obi_magic_mem_bridge

Overview:
- Parametrised bridge between the core's OBI-style port (req/gnt/rvalid, as on ibex instr_* and data_* ports) and a single magic-memory channel (read/write/resp).
- Replaces the direct tie of gnt and rvalid to the memory resp with a proper split handshake.
- Supports up to MAX_OUTSTANDING granted-but-unanswered requests, in-order responses, and an address-window error mode.
- One instance per core port, used in the magic_mem_sim top.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8; mbe width is DATA_W/8.
- MAX_OUTSTANDING, 2, maximum granted requests without rvalid; 1..8.
- WIN_BASE, 32'h0, base of the legal address window.
- WIN_SIZE, 32'h0, window size in bytes; 0 disables the range check (every address is legal).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_i  in  1  host request
- we_i  in  1  host write enable
- be_i  in  DATA_W/8  host byte enables
- addr_i  in  ADDR_W  host address
- wdata_i  in  DATA_W  host write data
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  response valid
- rdata_o  out  DATA_W  response read data
- err_o  out  1  response error
- mem_read_o  out  1  magic-memory read strobe
- mem_write_o  out  1  magic-memory write strobe
- mem_mbe_o  out  DATA_W/8  byte mask
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_resp_i  in  1  magic-memory completion
- mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Single clock clk. rst is synchronous, active-high.
- Reset: all outputs are 0, FSM is IDLE, outstanding count is 0, response FIFO is empty.

Grant:
- gnt_o = req_i && state==IDLE && (cnt < MAX_OUTSTANDING); combinational.
- On grant, the command (we, be, addr, wdata) is registered.

Command FSM:
- IDLE -> ISSUE on a grant with a legal address.
- IDLE -> ERR on a grant with an illegal address, i.e. WIN_SIZE!=0 and (addr < WIN_BASE or addr >= WIN_BASE+WIN_SIZE). The compare is done in ADDR_W+1 bits so the upper bound does not wrap.
- ISSUE:
  - mem_read_o = !we and mem_write_o = we, driven from the registered command.
  - mem_mbe_o = be for writes and all-ones for reads.
  - Strobes are held stable until mem_resp_i.
  - On mem_resp_i: push {rdata = mem_rdata_i for reads or 0 for writes, err = 0}, then -> IDLE.
- ERR: lasts one cycle; push {rdata = 0, err = 1}; no memory strobe is raised; -> IDLE.
- A new grant is possible in the cycle after the return to IDLE. Minimum issue cadence is 2 cycles per request.

Response path:
- Registered FIFO of depth MAX_OUTSTANDING.
- rvalid_o = !empty, with rdata_o/err_o taken from the head. The head is popped every cycle rvalid_o=1 (OBI has no rvalid backpressure).
- Latency: mem_resp_i at edge t gives rvalid_o=1 in the cycle after t. This is one cycle minimum even with an empty FIFO.
- Responses are always returned in grant order.

Counter:
- cnt increments on gnt_o and decrements on a rvalid_o pop; a simultaneous increment and decrement leaves it unchanged.
- cnt never exceeds MAX_OUTSTANDING, so the FIFO never overflows. Overflow is an assertion failure.
- A simultaneous push and pop on a full FIFO is legal.
- mem_resp_i while not in ISSUE is ignored; this includes a stale resp during or after reset.
- Reset mid-ISSUE: strobes drop in the cycle after the rst edge and pending responses are discarded.
- rdata_o and err_o are 0 whenever rvalid_o=0.

Assertions:
- mem_read_o and mem_write_o are never both 1.
- mem_addr_o is stable while a strobe is held.
- Every push occurs with FIFO space available.

Decomposition:
- Shared package obi_bridge_pkg holds:
  - typedef bridge_state_e {IDLE, ISSUE, ERR};
  - struct obi_cmd_t {we, be, addr, wdata};
  - struct obi_rsp_t {rdata, err};
  - the default window constants.
- Sub-module obi_rsp_fifo: parametrised synchronous FIFO with DEPTH and a width taken from obi_rsp_t. Same clk/rst; full/empty flags; pointer wrap-around by modulo DEPTH with a count register.

Test Plan:
- Single read: req at addr 0x100, memory returns 0xDEADBEEF after 3 cycles -> gnt in cycle 0; mem_read_o high for cycles 1-3 with mem_mbe_o=4'hF; rvalid_o with rdata_o=0xDEADBEEF and err_o=0 in cycle 4.
- Byte write: we=1, be=4'b0010, addr 0x104, wdata 0x0000AB00 -> mem_write_o with mem_mbe_o=4'b0010; on resp, rvalid_o with err_o=0 and rdata_o=0.
- Outstanding limit (MAX_OUTSTANDING=2): req held high, rvalid delayed by zero-latency memory -> gnt never raised while cnt==2; every rdata returned in order; no FIFO overflow.
- Window error (WIN_BASE=0x8000_0000, WIN_SIZE=0x1000): read at 0x8000_1000 -> no strobe; rvalid_o with err_o=1 two cycles after the grant. A read at 0x8000_0FFC -> normal access.
- Reset mid-ISSUE: rst pulsed during a held mem_read_o, followed by a late mem_resp_i -> strobes 0 in the cycle after reset; no rvalid_o; cnt=0.
- Back-to-back mixed read, write, error stream of 20 random transactions vs a scoreboard -> responses are exact and in order; the mutual-exclusion and address-stability assertions hold.

Source files
------------

// File: rtl/obi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obi_bridge_pkg
// Description : Shared types and constants for the OBI <-> magic-memory
//               bridge: command FSM state encoding, command and response
//               records at the default 32-bit geometry, and the default
//               legal-address window (size 0 = window check disabled).
// Revision    : 1.0  initial release
// ============================================================================
package obi_bridge_pkg;

    localparam int unsigned c_obi_addr_w = 32;
    localparam int unsigned c_obi_data_w = 32;

    // Default window: size 0 means every address is legal.
    localparam logic [31:0] c_def_win_base = 32'h0000_0000;
    localparam logic [31:0] c_def_win_size = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ERR   = 2'd2
    } bridge_state_e;

    typedef struct packed {
        logic                        we;
        logic [c_obi_data_w/8-1:0]   be;
        logic [c_obi_addr_w-1:0]     addr;
        logic [c_obi_data_w-1:0]     wdata;
    } obi_cmd_t;

    typedef struct packed {
        logic [c_obi_data_w-1:0]     rdata;
        logic                        err;
    } obi_rsp_t;

endpackage : obi_bridge_pkg
`default_nettype wire

// File: rtl/obi_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : obi_rsp_fifo
// Description : Synchronous response FIFO, DEPTH entries of WIDTH bits.
//               Read data is the current head (combinational from storage).
//               Pointers wrap modulo DEPTH; occupancy is kept in a counter so
//               non-power-of-two depths work. Push and pop in the same cycle
//               on a full FIFO is legal.
// Ports       : clk, rst          clock, synchronous active-high reset
//               i_push, i_wdata   write strobe and data
//               i_pop             remove head entry
//               o_rdata           head entry
//               o_full, o_empty   occupancy flags
// Revision    : 1.0  initial release
// ============================================================================
module obi_rsp_fifo
    import obi_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = $bits(obi_rsp_t)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        i_pop |-> !o_empty);

endmodule : obi_rsp_fifo
`default_nettype wire

// File: rtl/obi_magic_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : obi_magic_mem_bridge
// Description : Bridge from an OBI-style host port (req/gnt/rvalid) to a
//               single magic-memory channel (read/write strobes, resp).
//               Requests are granted only when the command FSM is idle and
//               fewer than MAX_OUTSTANDING responses are owed. Responses are
//               queued in a FIFO and returned in grant order, one cycle after
//               the memory completes. Addresses outside the optional window
//               [WIN_BASE, WIN_BASE+WIN_SIZE) get an error response without
//               touching memory.
// Ports       : clk, rst                      clock, sync active-high reset
//               req_i/we_i/be_i/addr_i/wdata_i host command
//               gnt_o                          command accepted this cycle
//               rvalid_o/rdata_o/err_o         host response
//               mem_read_o/mem_write_o         memory strobes
//               mem_mbe_o/mem_addr_o/mem_wdata_o memory command
//               mem_resp_i/mem_rdata_i         memory completion and data
// Revision    : 1.0  initial release
// ============================================================================
module obi_magic_mem_bridge
    import obi_bridge_pkg::*;
#(
    parameter int unsigned        ADDR_W          = 32,
    parameter int unsigned        DATA_W          = 32,
    parameter int unsigned        MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0]  WIN_BASE        = ADDR_W'(c_def_win_base),
    parameter logic [ADDR_W-1:0]  WIN_SIZE        = ADDR_W'(c_def_win_size)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                gnt_o,
    output logic                rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic [DATA_W/8-1:0] mem_mbe_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_resp_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int unsigned c_be_w  = DATA_W / 8;
    localparam int unsigned c_cnt_w = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_OUTSTANDING);

    typedef struct packed {
        logic                we;
        logic [c_be_w-1:0]   be;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
    } cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0]   rdata;
        logic                err;
    } rsp_t;

    bridge_state_e       r_state;
    bridge_state_e       w_state_nxt;
    cmd_t                r_cmd;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                w_addr_illegal;
    logic                w_issue;
    logic                w_push;
    rsp_t                w_push_rsp;
    logic                w_pop;
    rsp_t                w_fifo_head;
    logic                w_fifo_full;
    logic                w_fifo_empty;

    // ------------------------------------------------------------------
    // Address window check. The upper bound is formed one bit wider than
    // the address so a window touching the top of the space cannot wrap.
    // ------------------------------------------------------------------
    generate
        if (WIN_SIZE == '0) begin : g_no_window
            assign w_addr_illegal = 1'b0;
        end else begin : g_window
            localparam logic [ADDR_W:0] c_win_lo = {1'b0, WIN_BASE};
            localparam logic [ADDR_W:0] c_win_hi = {1'b0, WIN_BASE} + {1'b0, WIN_SIZE};
            logic [ADDR_W:0] w_addr_ext;
            assign w_addr_ext     = {1'b0, addr_i};
            assign w_addr_illegal = (w_addr_ext < c_win_lo) || (w_addr_ext >= c_win_hi);
        end
    endgenerate

    // Grant is masked during reset so every output reads 0 while rst is high.
    assign gnt_o = !rst && req_i && (r_state == IDLE) && (r_cnt < c_max_cnt);

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_rsp  = '0;
        case (r_state)
            IDLE: begin
                if (gnt_o) begin
                    w_state_nxt = w_addr_illegal ? ERR : ISSUE;
                end
            end
            ISSUE: begin
                // A resp seen in any other state is stale and is dropped.
                if (mem_resp_i) begin
                    w_push           = 1'b1;
                    w_push_rsp.rdata = r_cmd.we ? '0 : mem_rdata_i;
                    w_push_rsp.err   = 1'b0;
                    w_state_nxt      = IDLE;
                end
            end
            ERR: begin
                w_push         = 1'b1;
                w_push_rsp.err = 1'b1;
                w_state_nxt    = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The command only changes on a grant, which is impossible while ISSUE
    // holds the strobes, so the memory-side command is stable for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd <= '0;
        end else if (gnt_o) begin
            r_cmd <= '{we: we_i, be: be_i, addr: addr_i, wdata: wdata_i};
        end
    end

    // ------------------------------------------------------------------
    // Memory-side outputs, all zero outside ISSUE
    // ------------------------------------------------------------------
    assign w_issue     = (r_state == ISSUE);
    assign mem_read_o  = w_issue && !r_cmd.we;
    assign mem_write_o = w_issue &&  r_cmd.we;
    assign mem_mbe_o   = !w_issue ? '0 : (r_cmd.we ? r_cmd.be : '1);
    assign mem_addr_o  = w_issue ? r_cmd.addr : '0;
    assign mem_wdata_o = (w_issue && r_cmd.we) ? r_cmd.wdata : '0;

    // ------------------------------------------------------------------
    // Response path: OBI has no rvalid backpressure, so the head is
    // consumed in every cycle it is presented.
    // ------------------------------------------------------------------
    assign w_pop = !w_fifo_empty;

    obi_rsp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH ($bits(rsp_t))
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_push_rsp),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign rvalid_o = !w_fifo_empty;
    assign rdata_o  = w_fifo_empty ? '0   : w_fifo_head.rdata;
    assign err_o    = w_fifo_empty ? 1'b0 : w_fifo_head.err;

    // ------------------------------------------------------------------
    // Outstanding counter: granted requests whose response is not yet
    // returned. Bounding it by the FIFO depth guarantees push space.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case ({gnt_o, w_pop})
                2'b10:   r_cnt <= r_cnt + c_cnt_w'(1);
                2'b01:   r_cnt <= r_cnt - c_cnt_w'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
        !(mem_read_o && mem_write_o));

    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        ((mem_read_o || mem_write_o) && !mem_resp_i) |=> $stable(mem_addr_o));

    a_push_space: assert property (@(posedge clk) disable iff (rst)
        w_push |-> (!w_fifo_full || w_pop));

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        r_cnt <= c_max_cnt);

endmodule : obi_magic_mem_bridge
`default_nettype wire

// File: tb/tb_obi_magic_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_magic_mem_bridge
// Description : Self-checking bench for obi_magic_mem_bridge with a 4 KiB
//               legal window at 0x8000_0000. A magic-memory responder with a
//               programmable latency answers strobes; every grant pushes the
//               expected response into a queue that is popped and compared
//               whenever rvalid_o is seen.
// Revision    : 1.0  initial release
// ============================================================================
module tb_obi_magic_mem_bridge;

    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 32;
    localparam int          MAXO   = 2;
    localparam logic [31:0] WBASE  = 32'h8000_0000;
    localparam logic [31:0] WSIZE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i, wdata_i;
    logic        gnt_o, rvalid_o, err_o;
    logic [31:0] rdata_o;
    logic        mem_read_o, mem_write_o;
    logic [3:0]  mem_mbe_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_resp_i;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    obi_magic_mem_bridge #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .MAX_OUTSTANDING (MAXO),
        .WIN_BASE        (WBASE),
        .WIN_SIZE        (WSIZE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .mem_mbe_o   (mem_mbe_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_resp_i  (mem_resp_i),
        .mem_rdata_i (mem_rdata_i)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   mem_lat = 1;
    int   hold = 0;
    bit   stale_req = 1'b0;
    int   m_cnt = 0;
    int   s_cnt_pre = 0;

    logic        s_gnt, s_rvalid, s_err, s_rd, s_wr;
    logic [3:0]  s_mbe;
    logic [31:0] s_rdata, s_addr, s_wdata;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h8000_0100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic bit addr_legal(input logic [31:0] a);
        logic [32:0] lo, hi, x;
        lo = {1'b0, WBASE};
        hi = {1'b0, WBASE} + {1'b0, WSIZE};
        x  = {1'b0, a};
        return (x >= lo) && (x < hi);
    endfunction

    // One clock cycle: sample at negedge (scoreboard push on grant, pop on
    // rvalid), then update the memory responder just after the posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        s_gnt = gnt_o;   s_rvalid = rvalid_o; s_rdata = rdata_o; s_err = err_o;
        s_rd  = mem_read_o; s_wr = mem_write_o; s_mbe = mem_mbe_o;
        s_addr = mem_addr_o; s_wdata = mem_wdata_o;
        s_cnt_pre = m_cnt;
        if (gnt_o === 1'b1) begin
            e.err   = !addr_legal(addr_i);
            e.rdata = (e.err || we_i) ? 32'h0 : mem_model(addr_i);
            sb_q.push_back(e);
            m_cnt++;
        end
        total++;
        if (rvalid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: rvalid=1 rdata=%h err=%b, required no response", rdata_o, err_o);
            end else begin
                e = sb_q.pop_front();
                m_cnt--;
                if (rdata_o !== e.rdata || err_o !== e.err) begin
                    bad++;
                    $display("FAIL sb_rsp: rdata=%h err=%b, required rdata=%h err=%b", rdata_o, err_o, e.rdata, e.err);
                end
            end
        end else if (rvalid_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_rsp: rvalid=%b rdata=%h err=%b, required 0/0/0", rvalid_o, rdata_o, err_o);
        end
        @(posedge clk);
        #1;
        mem_resp_i  = 1'b0;
        mem_rdata_i = 32'h0;
        if (stale_req) begin
            mem_resp_i  = 1'b1;
            mem_rdata_i = 32'h5A5A_A5A5;
            stale_req   = 1'b0;
            hold        = 0;
        end else if (mem_read_o || mem_write_o) begin
            hold++;
            if (hold >= mem_lat) begin
                mem_resp_i  = 1'b1;
                mem_rdata_i = mem_read_o ? mem_model(mem_addr_o) : 32'hBAD0_0BAD;
                hold        = 0;
            end
        end else begin
            hold = 0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if ({s_gnt, s_rvalid, s_err, s_rd, s_wr} !== 5'b0 || s_rdata !== 32'h0) begin
                bad++;
                $display("FAIL reset_host: gnt=%b rvalid=%b err=%b rdata=%h, required all 0", s_gnt, s_rvalid, s_err, s_rdata);
            end
            total++;
            if (s_mbe !== 4'h0 || s_addr !== 32'h0 || s_wdata !== 32'h0 || s_rd !== 1'b0 || s_wr !== 1'b0) begin
                bad++;
                $display("FAIL reset_mem: rd=%b wr=%b mbe=%h addr=%h wdata=%h, required all 0", s_rd, s_wr, s_mbe, s_addr, s_wdata);
            end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        mem_lat = 3;
        req_i = 1'b1; we_i = 1'b0; be_i = 4'h3; addr_i = 32'h8000_0100; wdata_i = 32'h0;
        step();
        total++;
        if (s_gnt !== 1'b1) begin bad++; $display("FAIL single_gnt: gnt=%b, required 1", s_gnt); end
        req_i = 1'b0; be_i = 4'h0; addr_i = 32'h0;
        for (int c = 1; c <= 3; c++) begin
            step();
            total++;
            if (s_rd !== 1'b1 || s_wr !== 1'b0 || s_mbe !== 4'hF || s_addr !== 32'h8000_0100 || s_rvalid !== 1'b0) begin
                bad++;
                $display("FAIL single_strobe c%0d: rd=%b wr=%b mbe=%h addr=%h rvalid=%b, required 1/0/f/80000100/0", c, s_rd, s_wr, s_mbe, s_addr, s_rvalid);
            end
        end
        step();
        total++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'hDEAD_BEEF || s_err !== 1'b0 || s_rd !== 1'b0) begin
            bad++;
            $display("FAIL single_rsp: rvalid=%b rdata=%h err=%b rd=%b, required 1/deadbeef/0/0", s_rvalid, s_rdata, s_err, s_rd);
        end
        drain();
    endtask

    task automatic test_byte_write();
        int  n_wr = 0;
        bit  done = 1'b0;
        mem_lat = 2;
        req_i = 1'b1; we_i = 1'b1; be_i = 4'b0010; addr_i = 32'h8000_0104; wdata_i = 32'h0000_AB00;
        step();
        total++;
        if (s_gnt !== 1'b1) begin bad++; $display("FAIL write_gnt: gnt=%b, required 1", s_gnt); end
        req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 32'h0; wdata_i = 32'h0;
        for (int c = 0; c < 10 && !done; c++) begin
            step();
            if (s_wr === 1'b1) begin
                n_wr++;
                total++;
                if (s_mbe !== 4'b0010 || s_wdata !== 32'h0000_AB00 || s_addr !== 32'h8000_0104 || s_rd !== 1'b0) begin
                    bad++;
                    $display("FAIL write_strobe: mbe=%h wdata=%h addr=%h rd=%b, required 2/0000ab00/80000104/0", s_mbe, s_wdata, s_addr, s_rd);
                end
            end
            if (s_rvalid === 1'b1) begin
                done = 1'b1;
                total++;
                if (s_err !== 1'b0 || s_rdata !== 32'h0) begin
                    bad++;
                    $display("FAIL write_rsp: err=%b rdata=%h, required 0/0", s_err, s_rdata);
                end
            end
        end
        total++;
        if (!done || n_wr != 2) begin
            bad++;
            $display("FAIL write_cycles: done=%0d strobe_cycles=%0d, required 1/2", done, n_wr);
        end
        drain();
    endtask

    task automatic test_window_err();
        logic [31:0] addrs [3];
        logic        errs  [3];
        addrs[0] = 32'h8000_1000; errs[0] = 1'b1;
        addrs[1] = 32'h8000_0FFC; errs[1] = 1'b0;
        addrs[2] = 32'h7FFF_FFFC; errs[2] = 1'b1;
        mem_lat = 1;
        for (int k = 0; k < 3; k++) begin
            req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = addrs[k];
            step();
            total++;
            if (s_gnt !== 1'b1) begin bad++; $display("FAIL win_gnt %h: gnt=%b, required 1", addrs[k], s_gnt); end
            req_i = 1'b0; addr_i = 32'h0;
            step();
            total++;
            if (s_rd !== !errs[k] || s_wr !== 1'b0 || s_rvalid !== 1'b0) begin
                bad++;
                $display("FAIL win_strobe %h: rd=%b wr=%b rvalid=%b, required rd=%b wr=0 rvalid=0", addrs[k], s_rd, s_wr, s_rvalid, !errs[k]);
            end
            step();
            total++;
            if (s_rvalid !== 1'b1 || s_err !== errs[k] || s_rd !== 1'b0 ||
                s_rdata !== (errs[k] ? 32'h0 : mem_model(addrs[k]))) begin
                bad++;
                $display("FAIL win_rsp %h: rvalid=%b err=%b rdata=%h, required 1/%b", addrs[k], s_rvalid, s_err, s_rdata, errs[k]);
            end
        end
        drain();
    endtask

    task automatic test_outstanding();
        int n_gnt = 0;
        mem_lat = 1;
        req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h8000_0200;
        for (int c = 0; c < 16; c++) begin
            step();
            total++;
            if (s_gnt === 1'b1 && s_cnt_pre >= MAXO) begin
                bad++;
                $display("FAIL outst_limit c%0d: gnt=1 with %0d outstanding, required no grant", c, s_cnt_pre);
            end
            if (s_gnt === 1'b1) begin
                n_gnt++;
                addr_i = 32'h8000_0200 + 32'(n_gnt * 4);
            end
        end
        req_i = 1'b0;
        total++;
        if (n_gnt != 8) begin
            bad++;
            $display("FAIL outst_cadence: grants=%0d in 16 cycles, required 8", n_gnt);
        end
        drain();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL outst_drain: %0d responses missing, required 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid_issue();
        mem_lat = 100;
        req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h8000_0300;
        step();
        total++;
        if (s_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt: gnt=%b, required 1", s_gnt); end
        req_i = 1'b0;
        step();
        step();
        total++;
        if (s_rd !== 1'b1) begin bad++; $display("FAIL rmid_hold: rd=%b, required 1", s_rd); end
        rst = 1'b1;
        stale_req = 1'b1;
        sb_q.delete();
        m_cnt = 0;
        step();
        rst = 1'b0;
        step();
        total++;
        if (s_rd !== 1'b0 || s_wr !== 1'b0 || s_mbe !== 4'h0) begin
            bad++;
            $display("FAIL rmid_drop: rd=%b wr=%b mbe=%h, required 0/0/0", s_rd, s_wr, s_mbe);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (s_rvalid !== 1'b0 || s_rd !== 1'b0) begin
                bad++;
                $display("FAIL rmid_quiet c%0d: rvalid=%b rd=%b, required 0/0", c, s_rvalid, s_rd);
            end
        end
        mem_lat = 1;
        req_i = 1'b1; addr_i = 32'h8000_0304;
        step();
        total++;
        if (s_gnt !== 1'b1) begin bad++; $display("FAIL rmid_regrant: gnt=%b, required 1", s_gnt); end
        req_i = 1'b0;
        drain();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL rmid_after: %0d responses missing, required 0", sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int kind;
        bit got;
        for (int n = 0; n < 20; n++) begin
            kind    = int'($urandom_range(0, 9));
            we_i    = 1'($urandom_range(0, 1));
            be_i    = 4'($urandom_range(1, 15));
            wdata_i = $urandom;
            if (kind == 0)
                addr_i = 32'h8000_1000 + (32'($urandom_range(0, 255)) << 2);
            else if (kind == 1)
                addr_i = 32'h7FFF_F000 + (32'($urandom_range(0, 1023)) << 2);
            else
                addr_i = WBASE + (32'($urandom_range(0, 1023)) << 2);
            mem_lat = int'($urandom_range(1, 3));
            req_i   = 1'b1;
            got     = 1'b0;
            for (int w = 0; w < 12 && !got; w++) begin
                step();
                if (s_gnt === 1'b1) got = 1'b1;
            end
            total++;
            if (!got) begin
                bad++;
                $display("FAIL b2b_grant %0d: no grant in 12 cycles, required grant", n);
            end
        end
        req_i = 1'b0;
        drain();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain: %0d responses missing, required 0", sb_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 32'h0; wdata_i = 32'h0;
        mem_resp_i = 1'b0; mem_rdata_i = 32'h0;
        test_reset();
        test_single_read();
        test_byte_write();
        test_window_err();
        test_outstanding();
        test_reset_mid_issue();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_obi_magic_mem_bridge
`default_nettype wire
